// File: rtl/seven_seg_scanner_if.sv
// Signal bundle between the register-side driver (master) and the seven-segment scanner (slave).
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz_en;
    logic [3:0]          brightness;
    logic [DIGITS-1:0]   select;
    logic [7:0]          segments;
    logic                frame_start;

    modport master (
        output digits, dp, blank, lz_en, brightness,
        input  select, segments, frame_start
    );

    modport slave (
        input  digits, dp, blank, lz_en, brightness,
        output select, segments, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous capture and leading-zero
// suppression. Define SEVEN_SEG_BRIGHTNESS_EN to enable per-slot brightness PWM.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 4096
) (
    input  logic              clk,
    input  logic              reset,
    seven_seg_scanner_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                sh_lz_q, sh_lz_d;
    logic [DIGITS-1:0]   select_q, select_d;
    logic [7:0]          segments_q, segments_d;
    logic                frame_start_q, frame_start_d;
    logic                capture;
    logic                gate;
    logic [DIGITS-1:0]   suppress;

    function automatic logic [7:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    assign capture = (cnt_q == '0) && (idx_q == '0);

    // Decisions on the capture cycle use the freshly sampled inputs, so no frame ever tears.
    assign sh_digits_d = capture ? bus.digits : sh_digits_q;
    assign sh_dp_d     = capture ? bus.dp     : sh_dp_q;
    assign sh_blank_d  = capture ? bus.blank  : sh_blank_q;
    assign sh_lz_d     = capture ? bus.lz_en  : sh_lz_q;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    assign gate = (cnt_q[CNT_W-1 -: 4] <= bus.brightness);
`else
    logic brightness_unused;
    assign brightness_unused = ^bus.brightness;
    assign gate = 1'b1;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // Also catches out-of-range indices, returning them to digit 0.
            idx_d = (int'(idx_q) >= DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        logic higher_dark;
        higher_dark = 1'b1;
        suppress    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            suppress[i] = sh_lz_d && (sh_digits_d[4*i +: 4] == 4'h0) && !sh_dp_d[i] && higher_dark;
            higher_dark = suppress[i] || (higher_dark && sh_blank_d[i]);
        end
    end

    always_comb begin
        int idx_int;
        idx_int       = int'(idx_q);
        select_d      = '1;
        segments_d    = 8'hFF;
        frame_start_d = capture;
        if (idx_int < DIGITS && !sh_blank_d[idx_q] && !suppress[idx_q] && gate) begin
            select_d[idx_q] = 1'b0;
            segments_d      = hex_decode(sh_digits_d[4*idx_int +: 4]) & {~sh_dp_d[idx_q], 7'h7F};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            // NOTE: the shadows are reset so the display state is fully defined after reset.
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_lz_q       <= 1'b0;
            select_q      <= '1;
            segments_q    <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_lz_q       <= sh_lz_d;
            select_q      <= select_d;
            segments_q    <= segments_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.select      = select_q;
    assign bus.segments    = segments_q;
    assign bus.frame_start = frame_start_q;
endmodule
